// File: rtl/sng_pkg.sv
// Shared constants for the multi-channel stochastic number generator:
// maximal-length LFSR tap masks, per-channel seed salts and the FSM states.
package sng_pkg;

  // Fibonacci tap masks (bit i set => state[i] feeds the XOR), indexed by WIDTH
  localparam logic [15:0] TAPS [4:16] = '{
    16'h000C, 16'h0014, 16'h0030, 16'h0060, 16'h00B8, 16'h0110, 16'h0240,
    16'h0500, 16'h0E08, 16'h1C80, 16'h3802, 16'h6000, 16'hD008
  };

  // Decorrelates channels sharing one master seed; channel 0 uses the seed as-is
  localparam logic [15:0] CH_SALT [16] = '{
    16'h0000, 16'h0155, 16'h02AA, 16'h0333, 16'h00F0, 16'h030F, 16'h0196, 16'h0269,
    16'h5A3C, 16'hA5C3, 16'h3C5A, 16'hC3A5, 16'h6996, 16'h9669, 16'h0FF0, 16'hF00F
  };

  typedef enum logic {IDLE, RUN} state_e;

endpackage

// File: rtl/lfsr_sng_multi_if.sv
// Control/data bundle of the stochastic number generator.
interface lfsr_sng_multi_if #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 4,
  parameter int CW       = 10
) ();
  logic                      seed_load;
  logic [WIDTH-1:0]          seed;
  logic                      start;
  logic                      stall;
  logic [CHANNELS*WIDTH-1:0] prob;
  logic                      busy;
  logic [CHANNELS-1:0]       sbit;
  logic                      sbit_valid;
  logic                      done;
  logic [CHANNELS*WIDTH-1:0] rand_out;
  logic [CHANNELS*CW-1:0]    ones_count;

  modport master (output seed_load, seed, start, stall, prob,
                  input  busy, sbit, sbit_valid, done, rand_out, ones_count);
  modport slave  (input  seed_load, seed, start, stall, prob,
                  output busy, sbit, sbit_valid, done, rand_out, ones_count);
endinterface

// File: rtl/lfsr_channel.sv
// One Fibonacci LFSR: shifts left, feedback enters at bit 0.
module lfsr_channel
  import sng_pkg::*;
#(
  parameter int               WIDTH   = 10,
  parameter logic [WIDTH-1:0] RST_VAL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             adv,
  output logic [WIDTH-1:0] state
);
  localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH][WIDTH-1:0];

  logic fb;
  assign fb = ^(state & TAP_MASK);

  always_ff @(posedge clk) begin
    if (rst)       state <= RST_VAL;
    else if (load) state <= load_val;
    else if (adv)  state <= {state[WIDTH-2:0], fb};
  end
endmodule

// File: rtl/lfsr_sng_multi.sv
// Multi-channel SNG: per-channel LFSR vs. latched probability compare, emitting
// a STREAM_LEN-bit stochastic stream and a running ones-count per channel.
module lfsr_sng_multi
  import sng_pkg::*;
#(
  parameter int          WIDTH        = 10,
  parameter int          CHANNELS     = 4,
  parameter int          STREAM_LEN   = 1023,
  parameter logic [15:0] DEFAULT_SEED = 16'h0300
) (
  input  logic            clk,
  input  logic            rst,
  lfsr_sng_multi_if.slave bus
);
  localparam int CW = $clog2(STREAM_LEN + 1);

  if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
    $error("lfsr_sng_multi: WIDTH must be 4..16");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_chan
    $error("lfsr_sng_multi: CHANNELS must be 1..16");
  end
  if (STREAM_LEN < 1 || STREAM_LEN > 65535) begin : g_bad_len
    $error("lfsr_sng_multi: STREAM_LEN must be 1..65535");
  end

  // Rotate, salt, and never hand back the all-zero lockup state
  function automatic logic [WIDTH-1:0] chan_seed(input logic [WIDTH-1:0] s, input int c);
    logic [WIDTH-1:0] r;
    r = s;
    for (int i = 0; i < (c % WIDTH); i++) r = {r[WIDTH-2:0], r[WIDTH-1]};
    r = r ^ CH_SALT[c][WIDTH-1:0];
    if (r == '0) r = {{(WIDTH-1){1'b0}}, 1'b1};
    return r;
  endfunction

  state_e st, st_nxt;
  logic [CHANNELS-1:0][WIDTH-1:0] prob_q, lfsr, seed_v;
  logic [CHANNELS-1:0][CW-1:0]    ones_q;
  logic [CHANNELS-1:0]            lt, sbit_q;
  logic [CW-1:0]                  cnt;
  logic                           vld_q, done_q, ld, go, adv, last;

  assign ld   = (st == IDLE) && bus.seed_load;
  assign go   = (st == IDLE) && bus.start;
  assign adv  = (st == RUN) && !bus.stall;
  assign last = adv && (cnt == CW'(STREAM_LEN - 1));

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign seed_v[c] = chan_seed(bus.seed, c);
    assign lt[c]     = lfsr[c] < prob_q[c];

    lfsr_channel #(
      .WIDTH   (WIDTH),
      .RST_VAL (chan_seed(DEFAULT_SEED[WIDTH-1:0], c))
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .load     (ld),
      .load_val (seed_v[c]),
      .adv      (adv),
      .state    (lfsr[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (bus.start) st_nxt = RUN;
      RUN:     if (last)      st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      done_q <= 1'b0;
      sbit_q <= '0;
      ones_q <= '0;
      cnt    <= '0;
      prob_q <= '0;
    end else begin
      vld_q  <= adv;
      done_q <= last;
      if (go) begin
        prob_q <= bus.prob;
        ones_q <= '0;
        cnt    <= '0;
      end
      if (adv) begin
        sbit_q <= lt;
        cnt    <= cnt + CW'(1);
        for (int c = 0; c < CHANNELS; c++) ones_q[c] <= ones_q[c] + CW'(lt[c]);
      end
    end
  end

  assign bus.busy       = (st == RUN);
  assign bus.sbit       = sbit_q;
  assign bus.sbit_valid = vld_q;
  assign bus.done       = done_q;
  assign bus.rand_out   = lfsr;
  assign bus.ones_count = ones_q;
endmodule

// File: tb/tb_lfsr_sng_multi.sv
// Directed bench for lfsr_sng_multi (WIDTH=10, 4 channels, 1023-bit streams).
module tb_lfsr_sng_multi;
  localparam int W = 10, CH = 4, SL = 1023, CW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lfsr_sng_multi_if #(.WIDTH(W), .CHANNELS(CH), .CW(CW)) bus ();

  lfsr_sng_multi #(.WIDTH(W), .CHANNELS(CH), .STREAM_LEN(SL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0, n_bad = 0;
  int stall_at = -1, stall_len = 0, poke_at = -1, rst_at = -1;
  bit ld_with_start = 0;
  logic [W-1:0] ld_seed;
  int nvalid, ncyc;
  bit done_seen, zero_seen, aborted;
  int tb_ones [CH];
  logic [W-1:0] seq [3];
  logic [CH*W-1:0] probs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd(input int c);
    return bus.rand_out[c*W +: W];
  endfunction

  function automatic logic [CW-1:0] ones(input int c);
    return bus.ones_count[c*CW +: CW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e [CH];
    e = '{e0, e1, e2, e3};
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("%s_sbit_ch%0d", tag, c), tb_ones[c], e[c]);
      chk($sformatf("%s_cnt_ch%0d", tag, c), ones(c), e[c]);
    end
  endtask

  // Starts a stream and follows it to done (or abort), bounded at 3000 cycles
  task automatic run();
    bus.start = 1'b1;
    if (ld_with_start) begin
      bus.seed_load = 1'b1;
      bus.seed      = ld_seed;
    end
    tick();
    bus.start = 1'b0; bus.seed_load = 1'b0;
    seq[0] = rnd(0);
    nvalid = 0; ncyc = 0; done_seen = 0; zero_seen = 0; aborted = 0;
    for (int c = 0; c < CH; c++) tb_ones[c] = 0;
    while (!done_seen && !aborted && ncyc < 3000) begin
      bus.stall = (ncyc >= stall_at) && (ncyc < stall_at + stall_len);
      if (ncyc == poke_at) begin
        bus.start = 1'b1; bus.seed_load = 1'b1; bus.seed = 'h155; bus.prob = '0;
      end
      if (rst_at >= 0 && nvalid == rst_at) rst = 1'b1;
      tick();
      ncyc++;
      bus.start = 1'b0; bus.seed_load = 1'b0;
      if (rst) begin rst = 1'b0; aborted = 1; end
      if (bus.sbit_valid) begin
        nvalid++;
        for (int c = 0; c < CH; c++) tb_ones[c] += int'(bus.sbit[c]);
      end
      if (bus.done) begin
        done_seen = 1;
        chk("done_with_valid", bus.sbit_valid, 1);
        chk("busy_at_done", bus.busy, 0);
      end
      for (int c = 0; c < CH; c++) if (rnd(c) == '0) zero_seen = 1;
      if (ncyc <= 2) seq[ncyc] = rnd(0);
    end
    bus.stall = 1'b0;
    if (!done_seen && !aborted) chk("run_timeout", 0, 1);
  endtask

  initial begin
    // ch3=1, ch2=1023, ch1=0, ch0=512
    probs = {10'd1, 10'd1023, 10'd0, 10'd512};
    rst = 1'b1;
    bus.seed_load = 1'b0; bus.seed = '0; bus.start = 1'b0; bus.stall = 1'b0; bus.prob = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.sbit_valid, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sbit", bus.sbit, 0);
    chk("rst_ones", bus.ones_count, 0);
    chk("rst_ch0", rnd(0), 'h300);
    chk("rst_ch1", rnd(1), 'h354);

    // Sequence: prob=0 everywhere, ch0 steps 300 -> 201 -> 003
    bus.seed_load = 1'b1; bus.seed = 'h300;
    tick();
    bus.seed_load = 1'b0;
    run();
    chk("seq0", seq[0], 'h300);
    chk("seq1", seq[1], 'h201);
    chk("seq2", seq[2], 'h003);
    chk("seq_nvalid", nvalid, SL);
    chk_counts("seq", 0, 0, 0, 0);

    // Full period with boundary probabilities
    bus.prob = probs;
    run();
    chk("full_nvalid", nvalid, SL);
    chk("full_ncyc", ncyc, SL);
    chk("full_ch0_wrap", rnd(0), 'h300);
    chk_counts("full", 511, 0, 1022, 0);
    bus.prob = '0;
    tick(); tick(); tick();
    chk("idle_hold_ch0", ones(0), 511);
    chk("idle_hold_ch2", ones(2), 1022);
    chk("idle_busy", bus.busy, 0);

    // Zero seed maps to 1 on channel 0
    bus.prob = probs;
    bus.seed_load = 1'b1; bus.seed = '0;
    tick();
    bus.seed_load = 1'b0;
    chk("zero_seed_ch0", rnd(0), 1);
    run();
    chk("zero_nvalid", nvalid, SL);
    chk("zero_never_zero", zero_seen, 0);
    chk_counts("zero", 511, 0, 1022, 0);

    // Five stalled cycles mid-run
    stall_at = 100; stall_len = 5;
    run();
    stall_at = -1; stall_len = 0;
    chk("stall_nvalid", nvalid, SL);
    chk("stall_ncyc", ncyc, SL + 5);
    chk_counts("stall", 511, 0, 1022, 0);

    // start/seed_load/prob pokes mid-run must be ignored
    poke_at = 200;
    run();
    poke_at = -1;
    bus.prob = probs;
    chk("poke_nvalid", nvalid, SL);
    chk("poke_ncyc", ncyc, SL);
    chk("poke_ch0_wrap", rnd(0), 1);
    chk_counts("poke", 511, 0, 1022, 0);

    // seed_load together with start: run begins at the new seed
    ld_with_start = 1; ld_seed = 'h300;
    run();
    ld_with_start = 0;
    chk("ldst_seq0", seq[0], 'h300);
    chk("ldst_seq1", seq[1], 'h201);
    chk("ldst_nvalid", nvalid, SL);
    chk_counts("ldst", 511, 0, 1022, 0);

    // Reset after 300 valid bits aborts the run
    rst_at = 300;
    run();
    rst_at = -1;
    chk("abort_seen", aborted, 1);
    chk("abort_nvalid", nvalid, 300);
    chk("abort_no_done", done_seen, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_valid", bus.sbit_valid, 0);
    chk("abort_ones", bus.ones_count, 0);
    chk("abort_ch0", rnd(0), 'h300);
    tick(); tick();
    chk("abort_done_quiet", bus.done, 0);
    chk("abort_still_idle", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/lfsr_sng_multi.md
Name: lfsr_sng_multi

Overview:
- Parametrised multi-channel stochastic number generator (SNG) for the stochastic arithmetic path.
- Each channel runs its own Fibonacci LFSR of width WIDTH.
- Each channel compares its LFSR state against a per-channel probability word and emits one stochastic bit per cycle, for a programmable-length stream.
- Also accumulates the ones-count per channel, so downstream logic and benches can check the encoded value.

Parameters:
- WIDTH, 10, LFSR and probability width; legal 4..16 (tap table in package), otherwise elaboration error.
- CHANNELS, 4, number of independent LFSR/comparator channels.
- STREAM_LEN, 1023, bits emitted per run (1..2^16-1).
- DEFAULT_SEED, 10'b1100000000 (zero-extended/truncated to WIDTH), master seed applied at reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- seed_load  in  1  load seed into all channels; honoured only in IDLE.
- seed  in  WIDTH  master seed.
- start  in  1  begin a stream; honoured only in IDLE.
- stall  in  1  freeze the run for this cycle.
- prob  in  CHANNELS*WIDTH  per-channel probability words, channel c at [c*WIDTH +: WIDTH]; latched on start.
- busy  out  1  high while in RUN.
- sbit  out  CHANNELS  registered stochastic bits.
- sbit_valid  out  1  sbit is valid this cycle.
- done  out  1  one-cycle pulse, coincident with the last sbit_valid.
- rand_out  out  CHANNELS*WIDTH  current LFSR states.
- ones_count  out  CHANNELS*CW  per-channel count of ones emitted in the current or last run; CW = $clog2(STREAM_LEN+1).

Behaviour:
- All ports use one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: FSM = IDLE; busy, sbit, sbit_valid, done = 0; ones_count = 0; channel states = chan_seed(DEFAULT_SEED, c).
- Channel seed: chan_seed(s, c) = rotl(s, c) ^ CH_SALT[c]. If the result is all-zero, substitute 1. No channel can ever hold the all-zero lockup state.
- LFSR step: fb = XOR of the state bits at TAPS[WIDTH]; next = {state[WIDTH-2:0], fb}. For WIDTH=10 the taps are bits 9 and 6 (maximal length, period 1023).
- IDLE state:
  - seed_load=1 loads chan_seed(seed, c) into every channel.
  - start=1 latches prob, clears ones_count and the bit counter, and moves to RUN.
  - If seed_load and start are both high in the same cycle, both take effect; the run starts from the new seed.
  - LFSRs hold their value in IDLE.
- RUN state, each cycle with stall=0:
  - sbit[c] <= (state_c < prob_q[c]) as an unsigned compare.
  - sbit_valid <= 1.
  - ones_count[c] += sbit result.
  - state_c advances one step; counter increments.
- RUN state, stall=1: nothing advances and sbit_valid <= 0.
- Latency: with start sampled at edge E0, sbit_valid is first high after E1. Exactly STREAM_LEN valid cycles follow (excluding stalls).
- On the edge that registers the last bit (counter = STREAM_LEN-1):
  - done <= 1 for one cycle, alongside the last sbit_valid.
  - FSM returns to IDLE; busy drops in the same cycle that done rises.
- In IDLE, ones_count holds its value until the next start.
- start or seed_load during RUN are ignored.
- prob changes during RUN have no effect.
- Compare boundaries: prob=0 always gives sbit=0. prob=2^WIDTH-1 gives 0 only when the state is all ones.
- Reset mid-run aborts immediately: no done pulse, all reset values applied.

Decomposition:
- Package sng_pkg holds:
  - the TAPS table indexed by WIDTH (4..16), with maximal-length tap pairs/quads;
  - the CH_SALT constant array (channel 0 salt = 0);
  - the FSM state enum IDLE/RUN.
- One natural sub-module: lfsr_channel (params WIDTH; ports clk, rst, load, load_val, adv, state). Instantiate it CHANNELS times with a generate loop.
- The FSM, counter, comparators and ones_count accumulators live in the top level.

Test Plan:
- Sequence check: WIDTH=10, reset, seed_load seed=0x300, start, prob=0. Channel 0 rand_out must read 0x300, 0x201, 0x003 in successive run cycles, and all sbit=0.
- Full period: STREAM_LEN=1023, prob ch0=512, ch1=0, ch2=1023, ch3=1. Expect done after exactly 1023 valid cycles, ch0 state back at its seed, and ones_count = 511/0/1022/0.
- Zero seed: seed_load seed=0 → channel 0 state = 1 (not 0). The full run must complete, and no channel ever reads 0.
- Stall: stall asserted for 5 cycles mid-run → sbit_valid low for those 5 cycles, total valid count still 1023, done delayed by 5 cycles, ones_count unchanged versus the unstalled run.
- Ignore checks:
  - start and seed_load pulsed during RUN → no effect on sequence or counts.
  - prob changed mid-run → counts match the latched value.
  - seed_load+start in the same IDLE cycle → run starts from the new seed.
- Reset mid-run: rst at valid bit 300 → next cycle IDLE with busy=0, done never pulses, ones_count=0, ch0 state = DEFAULT_SEED (0x300).
